// File: rtl/edge_count_pkg.sv
// Shared encodings and the posedge/negedge classifier for the edge counter bank.
// Samples use 2-bit four-state encoding: 00=0, 01=1, 10=z, 11=x.
package edge_count_pkg;

    localparam logic [1:0] LV_0 = 2'b00;
    localparam logic [1:0] LV_1 = 2'b01;
    localparam logic [1:0] LV_Z = 2'b10;
    localparam logic [1:0] LV_X = 2'b11;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_POS  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef struct packed {
        logic pos;
        logic neg;
    } edge_t;

    // Leaving 0 toward anything is a rise and leaving 1 is a fall; from x/z only
    // a resolved 1 or 0 counts, so x<->z is never an edge.
    function automatic edge_t classify(input logic [1:0] prev, input logic [1:0] cur);
        edge_t e;
        e.pos = 1'b0;
        e.neg = 1'b0;
        case (prev)
            LV_0:    e.pos = (cur != LV_0);
            LV_1:    e.neg = (cur != LV_1);
            default: begin
                e.pos = (cur == LV_1);
                e.neg = (cur == LV_0);
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/edge_count_chan.sv
// One channel: last-sample register, rising/falling counters, and sticky overflow.
// Clear dominates any same-cycle edge, but the sample register always follows sig_i.
module edge_count_chan
    import edge_count_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sig_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] pos_cnt_o,
    output logic [CNT_W-1:0] neg_cnt_o,
    output logic             ovf_o
);

    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] neg_q, neg_d;
    logic             ovf_q, ovf_d;
    edge_t            edg;
    logic             pos_inc, neg_inc;

    assign edg     = classify(prev_q, sig_i);
    assign pos_inc = edg.pos && (mode_i == MODE_POS || mode_i == MODE_BOTH);
    assign neg_inc = edg.neg && (mode_i == MODE_NEG || mode_i == MODE_BOTH);

    always_comb begin
        prev_d = sig_i;
        pos_d  = pos_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (clr_i) begin
            pos_d = '0;
            neg_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (pos_inc) begin
                if (&pos_q) begin
                    ovf_d = 1'b1;
                    pos_d = (SATURATE != 0) ? pos_q : '0;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            if (neg_inc) begin
                if (&neg_q) begin
                    ovf_d = 1'b1;
                    neg_d = (SATURATE != 0) ? neg_q : '0;
                end else begin
                    neg_d = neg_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= LV_X;
            pos_q  <= '0;
            neg_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pos_cnt_o = pos_q;
    assign neg_cnt_o = neg_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/edge_count_bank.sv
// Bank of independent edge-counting channels with a one-cycle registered readout.
// Read data reflects counter values from before the requesting edge's update.
module edge_count_bank
    import edge_count_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int SATURATE = 1,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*CHANNELS-1:0] sig_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0]   clr_i,
    input  logic                  rd_en_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic                  rd_valid_o,
    output logic [CNT_W-1:0]      rd_pos_o,
    output logic [CNT_W-1:0]      rd_neg_o,
    output logic [CHANNELS-1:0]   ovf_o
);

    logic [CHANNELS-1:0][CNT_W-1:0] pos_cnt;
    logic [CHANNELS-1:0][CNT_W-1:0] neg_cnt;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        edge_count_chan #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig_i     (sig_i[2*c +: 2]),
            .mode_i    (mode_i[2*c +: 2]),
            .clr_i     (clr_i[c]),
            .pos_cnt_o (pos_cnt[c]),
            .neg_cnt_o (neg_cnt[c]),
            .ovf_o     (ovf_o[c])
        );
    end

    logic [CNT_W-1:0] sel_pos, sel_neg;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_pos_q, rd_pos_d;
    logic [CNT_W-1:0] rd_neg_q, rd_neg_d;

    // A select with no matching channel falls through to zeros.
    always_comb begin
        sel_pos = '0;
        sel_neg = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_sel_i == SEL_W'(c)) begin
                sel_pos = pos_cnt[c];
                sel_neg = neg_cnt[c];
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_en_i;
        rd_pos_d   = rd_en_i ? sel_pos : rd_pos_q;
        rd_neg_d   = rd_en_i ? sel_neg : rd_neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_pos_q   <= '0;
            rd_neg_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_pos_q   <= rd_pos_d;
            rd_neg_q   <= rd_neg_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_pos_o   = rd_pos_q;
    assign rd_neg_o   = rd_neg_q;

endmodule
